// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Stage indices double as bit positions in the per-stage freeze vector.
package pipe_ctrl_pkg;

  localparam int STALL_W = 5;
  localparam int PC_W    = 32;

  localparam int ST_PC  = 0;
  localparam int ST_IF  = 1;
  localparam int ST_ID  = 2;
  localparam int ST_EX  = 3;
  localparam int ST_MEM = 4;

  typedef enum logic {
    PEND_RUN  = 1'b0,
    PEND_HOLD = 1'b1
  } pend_state_e;

  typedef logic [STALL_W-1:0] stall_vec_t;

  // Freezing a stage also freezes every older stage, so each bit is the OR of itself and all younger requests.
  function automatic stall_vec_t freeze_upto_highest(input stall_vec_t req);
    logic acc;
    freeze_upto_highest = '0;
    acc = 1'b0;
    for (int k = STALL_W - 1; k >= 0; k--) begin
      acc = acc | req[k];
      freeze_upto_highest[k] = acc;
    end
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stall/flush bus between the pipeline stages and the controller.
// master = controller side, slave = pipeline side.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic            rdy;
  logic            if_req;
  logic            id_req;
  logic            ex_req;
  logic            mem_req;
  logic            jump_req;
  logic [PC_W-1:0] jump_target;
  stall_vec_t      stall_signal;
  logic            jump_flag;
  logic [PC_W-1:0] jump_pc;

  modport master (
    input  rdy, if_req, id_req, ex_req, mem_req, jump_req, jump_target,
    output stall_signal, jump_flag, jump_pc
  );

  modport slave (
    output rdy, if_req, id_req, ex_req, mem_req, jump_req, jump_target,
    input  stall_signal, jump_flag, jump_pc
  );

endinterface

// File: rtl/pipe_perf_cnt.sv
// Saturating performance counter: counts i_inc cycles, sticks at all-ones.
module pipe_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush producer: stall priority encoder, deferred-jump FSM and perf counters.
// Outputs are combinational from the requests and the pending-jump register (zero latency).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_if.master      io_pipe,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_count
);

  pend_state_e     r_state;
  pend_state_e     w_next_state;
  logic [PC_W-1:0] r_pend_tgt;
  logic [PC_W-1:0] w_next_tgt;
  logic [PC_W-1:0] w_eff_tgt;
  logic            w_eff_jump;
  logic            w_jump_flag;
  stall_vec_t      w_req;
  stall_vec_t      w_stall;
  logic            w_stall_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= PEND_RUN;
      r_pend_tgt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_pend_tgt <= w_next_tgt;
    end
  end

  // The flush only depends on EX/MEM holds, so masking IF/ID by it creates no loop.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_eff_jump   = io_pipe.jump_req | (r_state == PEND_HOLD);
    w_eff_tgt    = io_pipe.jump_req ? io_pipe.jump_target : r_pend_tgt;
    w_jump_flag  = w_eff_jump & io_pipe.rdy & ~(io_pipe.ex_req | io_pipe.mem_req);
    w_next_state = r_state;
    w_next_tgt   = r_pend_tgt;
    if (w_eff_jump && !w_jump_flag) begin
      w_next_state = PEND_HOLD;
      w_next_tgt   = w_eff_tgt;
    end else if (w_jump_flag) begin
      w_next_state = PEND_RUN;
    end
  end

  always_comb begin
    w_req         = '0;
    w_req[ST_PC]  = 1'b0;
    w_req[ST_IF]  = io_pipe.if_req & ~w_jump_flag;
    w_req[ST_ID]  = io_pipe.id_req & ~w_jump_flag;
    w_req[ST_EX]  = io_pipe.ex_req;
    w_req[ST_MEM] = io_pipe.mem_req;
    w_stall       = freeze_upto_highest(w_req);
  end

  always_comb begin
    io_pipe.stall_signal = '0;
    io_pipe.jump_flag    = 1'b0;
    io_pipe.jump_pc      = '0;
    if (!rst) begin
      io_pipe.stall_signal = io_pipe.rdy ? w_stall : '1;
      io_pipe.jump_flag    = w_jump_flag;
      io_pipe.jump_pc      = w_eff_tgt;
    end
  end

  assign w_stall_inc = io_pipe.rdy & (|io_pipe.stall_signal);

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_stall_inc),
    .o_count (o_stall_cycles)
  );

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (io_pipe.jump_flag),
    .o_count (o_flush_count)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic against a behavioural model.
// Two DUTs share stimulus; the 4-bit counter copy exercises saturation.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, if_req, id_req, ex_req, mem_req, jump_req;
  logic [31:0] jump_target;
  logic [31:0] sc32, fc32;
  logic [3:0]  sc4, fc4;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  bit          m_pend;
  logic [31:0] m_tgt;
  longint      m_sc32, m_fc32, m_sc4, m_fc4;

  logic [4:0]  exp_stall, act_stall, act_stall4;
  logic        exp_flag, act_flag, act_flag4;
  logic [31:0] exp_pc, act_pc;

  always #5 clk = ~clk;

  pipe_ctrl_if bus32 ();
  pipe_ctrl_if bus4 ();

  assign bus32.rdy = rdy;  assign bus32.if_req = if_req;  assign bus32.id_req = id_req;
  assign bus32.ex_req = ex_req;  assign bus32.mem_req = mem_req;
  assign bus32.jump_req = jump_req;  assign bus32.jump_target = jump_target;
  assign bus4.rdy = rdy;  assign bus4.if_req = if_req;  assign bus4.id_req = id_req;
  assign bus4.ex_req = ex_req;  assign bus4.mem_req = mem_req;
  assign bus4.jump_req = jump_req;  assign bus4.jump_target = jump_target;

  pipe_ctrl #(.CNT_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .io_pipe(bus32.master), .o_stall_cycles(sc32), .o_flush_count(fc32)
  );

  pipe_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .io_pipe(bus4.master), .o_stall_cycles(sc4), .o_flush_count(fc4)
  );

  function automatic longint sat_inc(input longint v, input int w);
    longint top;
    top = (longint'(1) << w) - 1;
    return (v >= top) ? top : v + 1;
  endfunction

  // One clock: sample outputs at negedge, derive expectations, advance the model at posedge.
  task automatic tick();
    int  h;
    bit  eff;
    @(negedge clk);
    act_stall  = bus32.stall_signal;
    act_flag   = bus32.jump_flag;
    act_pc     = bus32.jump_pc;
    act_stall4 = bus4.stall_signal;
    act_flag4  = bus4.jump_flag;
    eff      = jump_req || m_pend;
    exp_flag = !rst && rdy && eff && !ex_req && !mem_req;
    if (rst) exp_stall = 5'd0;
    else if (!rdy) exp_stall = 5'b11111;
    else begin
      h = -1;
      if (if_req && !exp_flag) h = 1;
      if (id_req && !exp_flag) h = 2;
      if (ex_req) h = 3;
      if (mem_req) h = 4;
      exp_stall = (h < 0) ? 5'd0 : 5'((1 << (h + 1)) - 1);
    end
    exp_pc = rst ? 32'd0 : (jump_req ? jump_target : m_tgt);
    @(posedge clk);
    if (rst) begin
      m_pend = 0; m_tgt = '0;
      m_sc32 = 0; m_fc32 = 0; m_sc4 = 0; m_fc4 = 0;
    end else begin
      if (rdy && exp_stall != 0) begin
        m_sc32 = sat_inc(m_sc32, 32); m_sc4 = sat_inc(m_sc4, 4);
      end
      if (exp_flag) begin
        m_fc32 = sat_inc(m_fc32, 32); m_fc4 = sat_inc(m_fc4, 4);
      end
      if (eff && !exp_flag) begin
        m_pend = 1; m_tgt = exp_pc;
      end else if (exp_flag) begin
        m_pend = 0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    rdy = 1; if_req = 0; id_req = 0; ex_req = 0; mem_req = 0; jump_req = 0;
  endtask

  task automatic test_reset();
    rst = 1; rdy = 1; if_req = 1; id_req = 1; ex_req = 1; mem_req = 1;
    jump_req = 1; jump_target = $urandom;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (act_stall !== 5'd0) begin n_bad++; $display("FAIL reset_stall act=%b exp=%b", act_stall, 5'd0); end
      n_cmp++; if (act_flag !== 1'b0) begin n_bad++; $display("FAIL reset_flag act=%b exp=0", act_flag); end
      n_cmp++; if (act_pc !== 32'd0) begin n_bad++; $display("FAIL reset_pc act=%h exp=0", act_pc); end
      n_cmp++; if (sc32 !== 32'd0 || fc32 !== 32'd0) begin n_bad++; $display("FAIL reset_cnt act=%0d/%0d exp=0/0", sc32, fc32); end
    end
    rst = 0; jump_req = 0;
    tick();
    n_cmp++; if (act_stall !== 5'b11111) begin n_bad++; $display("FAIL post_reset_stall act=%b exp=11111", act_stall); end
  endtask

  task automatic test_single_sources();
    logic [3:0] pats [6];   // {mem, ex, id, if}
    logic [4:0] wants [6];
    pats  = '{4'b0010, 4'b0100, 4'b0011, 4'b0000, 4'b1000, 4'b0001};
    wants = '{5'b00111, 5'b01111, 5'b00111, 5'b00000, 5'b11111, 5'b00011};
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      {mem_req, ex_req, id_req, if_req} = pats[i];
      tick();
      n_cmp++;
      if (act_stall !== wants[i]) begin
        n_bad++; $display("FAIL single_src[%0d] act=%b exp=%b", i, act_stall, wants[i]);
      end
    end
    n_cmp++; if (sc32 !== 32'(m_sc32)) begin n_bad++; $display("FAIL single_src_cnt act=%0d exp=%0d", sc32, m_sc32); end
  endtask

  task automatic test_plain_jump();
    longint fc_before;
    idle_inputs();
    fc_before = m_fc32;
    id_req = 1; jump_req = 1; jump_target = 32'h1040;
    tick();
    n_cmp++; if (act_flag !== 1'b1) begin n_bad++; $display("FAIL jump_flag act=%b exp=1", act_flag); end
    n_cmp++; if (act_pc !== 32'h1040) begin n_bad++; $display("FAIL jump_pc act=%h exp=1040", act_pc); end
    n_cmp++; if (act_stall !== 5'd0) begin n_bad++; $display("FAIL jump_squash act=%b exp=00000", act_stall); end
    n_cmp++; if (fc32 !== 32'(fc_before + 1)) begin n_bad++; $display("FAIL jump_cnt act=%0d exp=%0d", fc32, fc_before + 1); end
    jump_req = 0; id_req = 0;
    tick();
    n_cmp++; if (act_flag !== 1'b0) begin n_bad++; $display("FAIL jump_once act=%b exp=0", act_flag); end
  endtask

  task automatic test_deferred_jump();
    longint fc_before;
    idle_inputs();
    fc_before = m_fc32;
    mem_req = 1; jump_req = 1; jump_target = 32'h2000;
    tick();
    n_cmp++; if (act_flag !== 1'b0 || act_stall !== 5'b11111) begin
      n_bad++; $display("FAIL defer_first act=%b/%b exp=0/11111", act_flag, act_stall); end
    jump_req = 0;
    for (int i = 0; i < 3; i++) begin
      jump_target = $urandom;
      tick();
      n_cmp++; if (act_flag !== 1'b0) begin n_bad++; $display("FAIL defer_hold[%0d] act=%b exp=0", i, act_flag); end
    end
    mem_req = 0;
    tick();
    n_cmp++; if (act_flag !== 1'b1 || act_pc !== 32'h2000) begin
      n_bad++; $display("FAIL defer_fire act=%b/%h exp=1/2000", act_flag, act_pc); end
    tick();
    n_cmp++; if (act_flag !== 1'b0) begin n_bad++; $display("FAIL defer_single act=%b exp=0", act_flag); end
    n_cmp++; if (fc32 !== 32'(fc_before + 1)) begin n_bad++; $display("FAIL defer_cnt act=%0d exp=%0d", fc32, fc_before + 1); end
  endtask

  task automatic test_overwrite_and_rdy();
    longint fc_before, sc_before;
    idle_inputs();
    fc_before = m_fc32;
    ex_req = 1; jump_req = 1; jump_target = 32'h2500;
    tick();
    jump_target = 32'h3000;
    tick();
    n_cmp++; if (act_flag !== 1'b0) begin n_bad++; $display("FAIL ovw_hold act=%b exp=0", act_flag); end
    ex_req = 0; jump_req = 0;
    tick();
    n_cmp++; if (act_flag !== 1'b1 || act_pc !== 32'h3000) begin
      n_bad++; $display("FAIL ovw_fire act=%b/%h exp=1/3000", act_flag, act_pc); end
    tick();
    n_cmp++; if (fc32 !== 32'(fc_before + 1)) begin n_bad++; $display("FAIL ovw_cnt act=%0d exp=%0d", fc32, fc_before + 1); end
    sc_before = m_sc32;
    rdy = 0; jump_req = 1; jump_target = 32'h4444;
    for (int i = 0; i < 4; i++) begin
      {mem_req, ex_req, id_req, if_req} = 4'($urandom);
      tick();
      jump_req = 0;
      n_cmp++; if (act_stall !== 5'b11111 || act_flag !== 1'b0) begin
        n_bad++; $display("FAIL rdy0[%0d] act=%b/%b exp=11111/0", i, act_stall, act_flag); end
    end
    n_cmp++; if (sc32 !== 32'(sc_before)) begin n_bad++; $display("FAIL rdy0_cnt act=%0d exp=%0d", sc32, sc_before); end
    idle_inputs();
    tick();
    n_cmp++; if (act_flag !== 1'b1 || act_pc !== 32'h4444) begin
      n_bad++; $display("FAIL rdy0_capture act=%b/%h exp=1/4444", act_flag, act_pc); end
  endtask

  task automatic test_saturation_and_reset_hold();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0; id_req = 1;
    repeat (20) tick();
    n_cmp++; if (sc4 !== 4'd15) begin n_bad++; $display("FAIL sat4 act=%0d exp=15", sc4); end
    n_cmp++; if (sc32 !== 32'd20) begin n_bad++; $display("FAIL sat32 act=%0d exp=20", sc32); end
    id_req = 0; mem_req = 1; jump_req = 1; jump_target = 32'h5a5a0;
    tick();
    jump_req = 0; rst = 1;
    tick();
    rst = 0; mem_req = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (act_flag !== 1'b0 || act_pc !== 32'd0) begin
        n_bad++; $display("FAIL rst_hold[%0d] act=%b/%h exp=0/0", i, act_flag, act_pc); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 39) == 0);
      rdy         = ($urandom_range(0, 7) != 0);
      if_req      = ($urandom_range(0, 4) == 0);
      id_req      = ($urandom_range(0, 4) == 0);
      ex_req      = ($urandom_range(0, 5) == 0);
      mem_req     = ($urandom_range(0, 5) == 0);
      jump_req    = ($urandom_range(0, 6) == 0);
      jump_target = $urandom;
      tick();
      n_cmp++; if (act_stall !== exp_stall || act_stall4 !== exp_stall) begin
        n_bad++; $display("FAIL rnd_stall[%0d] act=%b/%b exp=%b", i, act_stall, act_stall4, exp_stall); end
      n_cmp++; if (act_flag !== exp_flag || act_flag4 !== exp_flag) begin
        n_bad++; $display("FAIL rnd_flag[%0d] act=%b/%b exp=%b", i, act_flag, act_flag4, exp_flag); end
      n_cmp++; if (act_pc !== exp_pc) begin
        n_bad++; $display("FAIL rnd_pc[%0d] act=%h exp=%h", i, act_pc, exp_pc); end
      n_cmp++; if (sc32 !== 32'(m_sc32) || fc32 !== 32'(m_fc32) || sc4 !== 4'(m_sc4) || fc4 !== 4'(m_fc4)) begin
        n_bad++; $display("FAIL rnd_cnt[%0d] act=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d",
                          i, sc32, fc32, sc4, fc4, m_sc32, m_fc32, m_sc4, m_fc4); end
    end
  endtask

  initial begin
    m_pend = 0; m_tgt = '0; m_sc32 = 0; m_fc32 = 0; m_sc4 = 0; m_fc4 = 0;
    test_reset();
    test_single_sources();
    test_plain_jump();
    test_deferred_jump();
    test_overwrite_and_rdy();
    test_saturation_and_reset_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
